wb_skid_stage: RTL and testbench

- Write-back stage between the MEM pipeline output and the register file write port (waddr/wdata/we).
- Holds up to two pending write-backs in an output register plus one skid entry, so a write-back stall does not drop MEM results.
- Presents at most one write per cycle to the register file, which gives same-cycle read-after-write forwarding on its read ports.

---
 rtl/wb_skid_stage_pkg.sv | 27 ++
 rtl/wb_entry_reg.sv | 33 +++
 rtl/wb_skid_stage.sv | 155 +++++++++++++++
 tb/tb_wb_skid_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_skid_stage_pkg.sv
// Shared register-file bus defines and write-back stage types.
// The defines are global to the compilation unit, so this file is compiled first.
`ifndef WB_SHARED_DEFINES
`define WB_SHARED_DEFINES
`define RegAddrBus   4:0
`define RegBus       31:0
`define NOPRegAddr   5'b00000
`define ZeroWord     32'h00000000
`define WriteEnable  1'b1
`define WriteDisable 1'b0
`define WbCntBus     1:0
`endif

package wb_skid_stage_pkg;

  // State encoding doubles as the pending-entry count.
  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_ONE   = 2'd1,
    WB_TWO   = 2'd2
  } wb_state_e;

  function automatic logic [1:0] wb_cnt(input wb_state_e s);
    return logic'(s == WB_TWO) ? 2'd2 : (s == WB_ONE) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/wb_entry_reg.sv
// One pending write-back entry: {valid, waddr, wdata} with load and clear.
// Only the valid bit is reset; address/data are qualified by valid downstream.
module wb_entry_reg #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Valid flag: clear wins over load so a flush always empties the entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       valid <= 1'b0;
    else if (clear) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
  end

  // Payload capture on load; stale contents are harmless once valid drops.
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      addr <= in_addr;
      data <= in_data;
    end
  end

endmodule

// File: rtl/wb_skid_stage.sv
// Write-back stage: output register plus one skid entry between MEM and the
// register file write port. Presents at most one write per cycle, in order.
// Optional pending-entry forwarding to ID is enabled by WB_PENDING_FWD_EN.
module wb_skid_stage
  import wb_skid_stage_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              wb_stall,
  input  logic              flush,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_we,
  output logic [`WbCntBus]  wb_count
`ifdef WB_PENDING_FWD_EN
  ,
  input  logic [ADDR_W-1:0] fwd_raddr1,
  input  logic [ADDR_W-1:0] fwd_raddr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
`endif
);

  wb_state_e state, state_nx;

  logic              accept, enq, fire;
  logic              out_load, out_clear, out_sel_skid;
  logic              skid_load, skid_clear;
  logic              out_valid, skid_valid;
  logic [ADDR_W-1:0] out_addr, skid_addr, out_in_addr;
  logic [DATA_W-1:0] out_data, skid_data, out_in_data;

  // Items that write nothing (no wreg, or r0) are consumed without a slot.
  assign accept = mem_valid & mem_ready & ~flush;
  assign enq    = accept & mem_wreg & (mem_wd != '0);
  assign fire   = out_valid & ~wb_stall & ~flush;

  // Output entry refills from MEM, or from the skid when draining TWO.
  assign out_in_addr = out_sel_skid ? skid_addr : mem_wd;
  assign out_in_data = out_sel_skid ? skid_data : mem_wdata;

  wb_entry_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_out (
    .clk     (clk),
    .rst     (rst),
    .load    (out_load),
    .clear   (out_clear),
    .in_addr (out_in_addr),
    .in_data (out_in_data),
    .valid   (out_valid),
    .addr    (out_addr),
    .data    (out_data)
  );

  wb_entry_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clear),
    .in_addr (mem_wd),
    .in_data (mem_wdata),
    .valid   (skid_valid),
    .addr    (skid_addr),
    .data    (skid_data)
  );

  // State register; ready is registered from the next count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WB_EMPTY;
      mem_ready <= 1'b1;
    end else begin
      state     <= state_nx;
      mem_ready <= (state_nx != WB_TWO);
    end
  end

  // Next-state and entry controls; flush overrides accept and fire.
  always_comb begin
    state_nx     = state;
    out_load     = 1'b0;
    out_clear    = 1'b0;
    out_sel_skid = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    if (flush) begin
      state_nx   = WB_EMPTY;
      out_clear  = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        WB_EMPTY: begin
          if (enq) begin
            out_load = 1'b1;
            state_nx = WB_ONE;
          end
        end
        WB_ONE: begin
          if (enq && fire) begin
            out_load = 1'b1;
          end else if (enq) begin
            skid_load = 1'b1;
            state_nx  = WB_TWO;
          end else if (fire) begin
            out_clear = 1'b1;
            state_nx  = WB_EMPTY;
          end
        end
        WB_TWO: begin
          if (fire && skid_valid) begin
            out_load     = 1'b1;
            out_sel_skid = 1'b1;
            skid_clear   = 1'b1;
            state_nx     = WB_ONE;
          end
        end
        default: state_nx = WB_EMPTY;
      endcase
    end
  end

  // Register-file port, zeroed whenever no output entry is held.
  always_comb begin
    wb_we    = fire;
    wb_waddr = out_valid ? out_addr : '0;
    wb_wdata = out_valid ? out_data : '0;
    wb_count = wb_cnt(state);
  end

`ifdef WB_PENDING_FWD_EN
  // Newest matching entry wins; r0 never hits.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] raddr);
    if (raddr == '0)                        return '0;
    else if (skid_valid && skid_addr == raddr) return {1'b1, skid_data};
    else if (out_valid && out_addr == raddr)   return {1'b1, out_data};
    else                                     return '0;
  endfunction

  // Combinational lookup for both ID read ports.
  always_comb begin
    {fwd_hit1, fwd_data1} = fwd_lookup(fwd_raddr1);
    {fwd_hit2, fwd_data2} = fwd_lookup(fwd_raddr2);
  end
`endif

endmodule

// File: tb/tb_wb_skid_stage.sv
// Bench for wb_skid_stage: queue model of pending writes checked every cycle,
// plus directed literal expectations. Forwarding checks need WB_PENDING_FWD_EN.
module tb_wb_skid_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_wd = '0;
  logic        mem_wreg = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic        wb_stall = 1'b0;
  logic        flush = 1'b0;
  logic        mem_ready;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic [1:0]  wb_count;
`ifdef WB_PENDING_FWD_EN
  logic [4:0]  fwd_raddr1 = '0;
  logic [4:0]  fwd_raddr2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  int tests = 0;
  int fails = 0;

  wb_skid_stage #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .wb_stall  (wb_stall),
    .flush     (flush),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .wb_we     (wb_we),
    .wb_count  (wb_count)
`ifdef WB_PENDING_FWD_EN
    ,
    .fwd_raddr1 (fwd_raddr1),
    .fwd_raddr2 (fwd_raddr2),
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  // Model: FIFO of pending writes in acceptance order, capacity two.
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t q[$];
  bit  m_ready = 1'b1;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        m_ready = 1'b1;
      end else begin
        bit acc, fr;
        acc = mem_valid && m_ready && !flush;
        fr  = (q.size() > 0) && !wb_stall && !flush;
        if (flush) q.delete();
        else begin
          if (fr) void'(q.pop_front());
          if (acc && mem_wreg && mem_wd != 5'd0) q.push_back('{mem_wd, mem_wdata});
        end
        m_ready = (q.size() < 2);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    e_we   = (q.size() > 0) && !wb_stall && !flush && rst;
    e_addr = (q.size() > 0) ? q[0].addr : 5'd0;
    e_data = (q.size() > 0) ? q[0].data : 32'd0;
    chk("model_we",    {31'd0, wb_we},     {31'd0, e_we});
    chk("model_waddr", {27'd0, wb_waddr},  {27'd0, e_addr});
    chk("model_wdata", wb_wdata,           e_data);
    chk("model_count", {30'd0, wb_count},  q.size());
    chk("model_ready", {31'd0, mem_ready}, {31'd0, m_ready});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [4:0] wd, input logic wr, input logic [31:0] d);
    mem_valid = v;
    mem_wd    = wd;
    mem_wreg  = wr;
    mem_wdata = d;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_we",    {31'd0, wb_we}, 32'd0);
    chk("rst_waddr", {27'd0, wb_waddr}, 32'd0);
    chk("rst_wdata", wb_wdata, 32'd0);
    chk("rst_count", {30'd0, wb_count}, 32'd0);
    chk("rst_ready", {31'd0, mem_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Single write, fires the cycle after acceptance
    offer(1, 5'd3, 1, 32'h11111111);
    chk("t1_no_early_we", {31'd0, wb_we}, 32'd0);
    step();
    offer(0, 5'd0, 0, 32'd0);
    #1;
    chk("t1_we",    {31'd0, wb_we}, 32'd1);
    chk("t1_waddr", {27'd0, wb_waddr}, 32'd3);
    chk("t1_wdata", wb_wdata, 32'h11111111);
    step();
    chk("t1_count_after", {30'd0, wb_count}, 32'd0);

    // Back-to-back accepts 1..4
    for (int i = 1; i <= 4; i++) begin
      offer(1, 5'(i), 1, 32'(i) * 32'h10);
      step();
      chk("b2b_we",    {31'd0, wb_we}, 32'd1);
      chk("b2b_waddr", {27'd0, wb_waddr}, 32'(i));
      chk("b2b_ready", {31'd0, mem_ready}, 32'd1);
    end
    offer(0, 5'd0, 0, 32'd0);
    step();
    chk("b2b_empty", {30'd0, wb_count}, 32'd0);

    // Stall with three offers: two taken, third held until space frees
    wb_stall = 1'b1;
    offer(1, 5'd8, 1, 32'h80);
    step();
    offer(1, 5'd9, 1, 32'h90);
    step();
    chk("stall_count2", {30'd0, wb_count}, 32'd2);
    chk("stall_ready0", {31'd0, mem_ready}, 32'd0);
    offer(1, 5'd10, 1, 32'hA0);
    step();
    step();
    chk("stall_hold_cnt", {30'd0, wb_count}, 32'd2);
    chk("stall_hold_we",  {31'd0, wb_we}, 32'd0);
    chk("stall_hold_addr", {27'd0, wb_waddr}, 32'd8);
    wb_stall = 1'b0;
    #1;
    chk("drain1_addr", {27'd0, wb_waddr}, 32'd8);
    chk("drain1_we",   {31'd0, wb_we}, 32'd1);
    step();
    chk("drain2_addr", {27'd0, wb_waddr}, 32'd9);
    chk("drain2_ready", {31'd0, mem_ready}, 32'd1);
    step();
    offer(0, 5'd0, 0, 32'd0);
    #1;
    chk("drain3_addr", {27'd0, wb_waddr}, 32'd10);
    chk("drain3_data", wb_wdata, 32'hA0);
    step();
    chk("drain_empty", {30'd0, wb_count}, 32'd0);

    // Dropped items between 5 and 6
    offer(1, 5'd5, 1, 32'h55);
    step();
    chk("drop_5", {27'd0, wb_waddr}, 32'd5);
    offer(1, 5'd0, 1, 32'hDEAD);
    step();
    chk("drop_r0_cnt", {30'd0, wb_count}, 32'd0);
    offer(1, 5'd7, 0, 32'hBEEF);
    step();
    chk("drop_nowreg_cnt", {30'd0, wb_count}, 32'd0);
    chk("drop_nowreg_we", {31'd0, wb_we}, 32'd0);
    offer(1, 5'd6, 1, 32'h66);
    step();
    offer(0, 5'd0, 0, 32'd0);
    #1;
    chk("drop_6", {27'd0, wb_waddr}, 32'd6);
    chk("drop_6_data", wb_wdata, 32'h66);
    step();

    // Flush at count=2, with an offer present
    wb_stall = 1'b1;
    offer(1, 5'd11, 1, 32'hB1);
    step();
    offer(1, 5'd12, 1, 32'hB2);
    step();
    chk("fl_pre_cnt", {30'd0, wb_count}, 32'd2);
    wb_stall = 1'b0;
    flush = 1'b1;
    offer(1, 5'd13, 1, 32'hB3);
    #1;
    chk("fl_we", {31'd0, wb_we}, 32'd0);
    step();
    flush = 1'b0;
    offer(0, 5'd0, 0, 32'd0);
    #1;
    chk("fl_cnt", {30'd0, wb_count}, 32'd0);
    chk("fl_ready", {31'd0, mem_ready}, 32'd1);
    // Flush while ready=1: offer in the flush cycle is ignored
    flush = 1'b1;
    offer(1, 5'd14, 1, 32'hC4);
    step();
    flush = 1'b0;
    offer(0, 5'd0, 0, 32'd0);
    #1;
    chk("fl_ignored_cnt", {30'd0, wb_count}, 32'd0);
    step();

`ifdef WB_PENDING_FWD_EN
    // Skid entry has priority over the output entry
    wb_stall = 1'b1;
    offer(1, 5'd7, 1, 32'hA);
    step();
    offer(1, 5'd7, 1, 32'hB);
    step();
    offer(0, 5'd0, 0, 32'd0);
    fwd_raddr1 = 5'd7;
    fwd_raddr2 = 5'd0;
    #1;
    chk("fwd_hit1",  {31'd0, fwd_hit1}, 32'd1);
    chk("fwd_data1", fwd_data1, 32'hB);
    chk("fwd_hit2",  {31'd0, fwd_hit2}, 32'd0);
    chk("fwd_data2", fwd_data2, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wb_stall = 1'b0;
    step();
`endif

    // Asynchronous reset mid-operation at count=2
    wb_stall = 1'b1;
    offer(1, 5'd20, 1, 32'h200);
    step();
    offer(1, 5'd21, 1, 32'h210);
    step();
    offer(0, 5'd0, 0, 32'd0);
    chk("ar_pre_cnt", {30'd0, wb_count}, 32'd2);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_cnt",   {30'd0, wb_count}, 32'd0);
    chk("ar_waddr", {27'd0, wb_waddr}, 32'd0);
    chk("ar_wdata", wb_wdata, 32'd0);
    chk("ar_ready", {31'd0, mem_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    wb_stall = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

●
